// File: rtl/seven_segment_pkg.sv
// Shared seven-segment definitions.
// Active-low pattern table used by both encoder and capture decoder.
package seven_segment_pkg;

  localparam int SEG_WIDTH = 7;

  localparam logic [SEG_WIDTH-1:0] SEG_BLANK = 7'h7F;

  localparam logic [SEG_WIDTH-1:0] SEG_TABLE [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06,
    7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60,
    7'h31, 7'h42, 7'h30, 7'h38
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLING,
    ST_STABLE
  } cap_state_e;

endpackage

// File: rtl/seven_segment_pattern_lookup.sv
// Segment pattern lookup.
// Maps an active-low pattern back to its hex nibble.
module seven_segment_pattern_lookup
  import seven_segment_pkg::*;
(
  input  logic [SEG_WIDTH-1:0] pattern,
  output logic                 hit,
  output logic                 blank,
  output logic [3:0]           nibble
);

  // search the shared table for a matching digit
  always_comb begin
    hit    = 1'b0;
    nibble = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (pattern == SEG_TABLE[i]) begin
        hit    = 1'b1;
        nibble = 4'(i);
      end
    end
  end

  assign blank = (pattern == SEG_BLANK);

endmodule

// File: rtl/seven_segment_capture_decoder.sv
// Seven-segment capture decoder.
// Synchronises segment lines, qualifies stability, decodes.
module seven_segment_capture_decoder
  import seven_segment_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Segment_A,
  input  logic       i_Segment_B,
  input  logic       i_Segment_C,
  input  logic       i_Segment_D,
  input  logic       i_Segment_E,
  input  logic       i_Segment_F,
  input  logic       i_Segment_G,
  output logic [3:0] o_Nibble,
  output logic       o_Valid,
  output logic       o_Blank,
  output logic       o_Error,
  output logic       o_Change_Pulse,
  output logic       o_Settling
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);

  logic [SEG_WIDTH-1:0] raw;
  logic [SEG_WIDTH-1:0] pins;
  logic [SEG_WIDTH-1:0] sync1_q;
  logic [SEG_WIDTH-1:0] sync2_q;
  logic [SEG_WIDTH-1:0] prev_q;
  cap_state_e           state_q;
  cap_state_e           state_d;
  logic [CW-1:0]        cnt_q;
  logic [CW-1:0]        cnt_d;
  logic                 dec;
  logic                 lk_hit;
  logic                 lk_blank;
  logic [3:0]           lk_nibble;
  logic                 same;

  assign raw = {i_Segment_A, i_Segment_B, i_Segment_C,
                i_Segment_D, i_Segment_E, i_Segment_F,
                i_Segment_G};

  assign pins = ACTIVE_LOW ? raw : ~raw;
  assign same = (sync2_q == prev_q);

  seven_segment_pattern_lookup u_lookup (
    .pattern (sync2_q),
    .hit     (lk_hit),
    .blank   (lk_blank),
    .nibble  (lk_nibble)
  );

  // two-flop synchroniser plus previous-sample register
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      sync1_q <= SEG_BLANK;
      sync2_q <= SEG_BLANK;
      prev_q  <= SEG_BLANK;
    end else begin
      sync1_q <= pins;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // qualification state and stability counter
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // next state: decode on the edge the count reaches its threshold
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dec     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_SETTLING;
        cnt_d   = '0;
      end
      ST_SETTLING: begin
        if (!same) begin
          cnt_d = '0;
        end else if (int'(cnt_q) + 2 >= STABLE_CYCLES) begin
          dec     = 1'b1;
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STABLE: begin
        if (!same) begin
          state_d = ST_SETTLING;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // status outputs update only on a decode
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      o_Nibble       <= 4'h0;
      o_Valid        <= 1'b0;
      o_Blank        <= 1'b0;
      o_Error        <= 1'b0;
      o_Change_Pulse <= 1'b0;
    end else begin
      o_Change_Pulse <= 1'b0;
      if (dec) begin
        if (lk_hit) begin
          o_Nibble       <= lk_nibble;
          o_Valid        <= 1'b1;
          o_Blank        <= 1'b0;
          o_Error        <= 1'b0;
          o_Change_Pulse <= !o_Valid || (o_Nibble != lk_nibble);
        end else if (lk_blank) begin
          o_Valid <= 1'b0;
          o_Blank <= 1'b1;
          o_Error <= 1'b0;
        end else begin
          o_Valid <= 1'b0;
          o_Blank <= 1'b0;
          o_Error <= 1'b1;
        end
      end
    end
  end

  assign o_Settling = (state_q == ST_SETTLING);

endmodule

// File: tb/tb_seven_segment_capture_decoder.sv
// Testbench for seven_segment_capture_decoder.
// Directed vectors, both polarities, hand-computed expectations.
module tb_seven_segment_capture_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] seg = 7'h01;
  logic [6:0] seg_ah;

  logic [3:0] nib, nib_ah;
  logic       vld, vld_ah;
  logic       blk, blk_ah;
  logic       err, err_ah;
  logic       pls, pls_ah;
  logic       stl, stl_ah;

  int n_checks = 0;
  int n_errors = 0;
  int pc = 0;
  int pc_ah = 0;

  logic [6:0] tbl [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06,
    7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60,
    7'h31, 7'h42, 7'h30, 7'h38
  };

  assign seg_ah = ~seg;

  always #5 clk = ~clk;

  seven_segment_capture_decoder #(
    .STABLE_CYCLES (4),
    .ACTIVE_LOW    (1'b1)
  ) dut (
    .i_Clk          (clk),
    .i_Reset        (rst),
    .i_Segment_A    (seg[6]),
    .i_Segment_B    (seg[5]),
    .i_Segment_C    (seg[4]),
    .i_Segment_D    (seg[3]),
    .i_Segment_E    (seg[2]),
    .i_Segment_F    (seg[1]),
    .i_Segment_G    (seg[0]),
    .o_Nibble       (nib),
    .o_Valid        (vld),
    .o_Blank        (blk),
    .o_Error        (err),
    .o_Change_Pulse (pls),
    .o_Settling     (stl)
  );

  seven_segment_capture_decoder #(
    .STABLE_CYCLES (4),
    .ACTIVE_LOW    (1'b0)
  ) dut_ah (
    .i_Clk          (clk),
    .i_Reset        (rst),
    .i_Segment_A    (seg_ah[6]),
    .i_Segment_B    (seg_ah[5]),
    .i_Segment_C    (seg_ah[4]),
    .i_Segment_D    (seg_ah[3]),
    .i_Segment_E    (seg_ah[2]),
    .i_Segment_F    (seg_ah[1]),
    .i_Segment_G    (seg_ah[0]),
    .o_Nibble       (nib_ah),
    .o_Valid        (vld_ah),
    .o_Blank        (blk_ah),
    .o_Error        (err_ah),
    .o_Change_Pulse (pls_ah),
    .o_Settling     (stl_ah)
  );

  always @(negedge clk) begin
    if (pls)    pc++;
    if (pls_ah) pc_ah++;
  end

  task automatic check_eq(input string tag,
                          input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  int  p0, p0_ah;
  logic saw;

  initial begin
    // reset held three edges with digit 0 on the pins
    rst = 1'b1;
    seg = 7'h01;
    tick(3);
    check_eq("rst_out", {26'd0, nib, vld, blk, err, pls, stl}, 32'd0);
    check_eq("rst_out_ah",
             {26'd0, nib_ah, vld_ah, blk_ah, err_ah, pls_ah, stl_ah},
             32'd0);
    rst = 1'b0;
    tick(1);
    check_eq("idle_to_settling", {31'd0, stl}, 32'd1);
    tick(10);
    check_eq("first_digit0", {27'd0, vld, nib}, {27'd0, 1'b1, 4'h0});
    check_eq("first_pulse", pc, 1);

    // digit 7: pulse exactly six edges after the pin change
    seg = 7'h0F;
    for (int e = 1; e <= 7; e++) begin
      tick(1);
      check_eq($sformatf("lat7_pulse_e%0d", e), {31'd0, pls},
               (e == 6) ? 32'd1 : 32'd0);
      if (e == 5)
        check_eq("lat7_hold_e5", {28'd0, nib}, 32'd0);
      if (e == 6)
        check_eq("lat7_val_e6", {27'd0, vld, nib}, {27'd0, 1'b1, 4'h7});
    end

    // glitch on steady 3 never decodes and never pulses
    seg = 7'h06;
    tick(10);
    check_eq("steady3", {28'd0, nib}, 32'd3);
    p0  = pc;
    saw = 1'b0;
    seg = 7'h4C;
    tick(2);
    seg = 7'h06;
    for (int k = 0; k < 12; k++) begin
      tick(1);
      if (stl) saw = 1'b1;
    end
    check_eq("glitch_settling", {31'd0, saw}, 32'd1);
    check_eq("glitch_no_pulse", pc - p0, 0);
    check_eq("glitch_hold3", {27'd0, vld, nib}, {27'd0, 1'b1, 4'h3});

    // illegal pattern then blank
    seg = 7'h55;
    tick(10);
    check_eq("illegal", {25'd0, nib, vld, blk, err},
             {25'd0, 4'h3, 1'b0, 1'b0, 1'b1});
    seg = 7'h7F;
    tick(10);
    check_eq("blank", {25'd0, nib, vld, blk, err},
             {25'd0, 4'h3, 1'b0, 1'b1, 1'b0});
    check_eq("blank_ah", {25'd0, nib_ah, vld_ah, blk_ah, err_ah},
             {25'd0, 4'h3, 1'b0, 1'b1, 1'b0});

    // all sixteen digits, both polarities
    p0    = pc;
    p0_ah = pc_ah;
    for (int d = 0; d < 16; d++) begin
      seg = tbl[d];
      tick(8);
      check_eq($sformatf("loop_%0h", d), {27'd0, vld, nib},
               {27'd0, 1'b1, 4'(d)});
      check_eq($sformatf("loop_ah_%0h", d), {27'd0, vld_ah, nib_ah},
               {27'd0, 1'b1, 4'(d)});
    end
    check_eq("loop_pulses", pc - p0, 16);
    check_eq("loop_pulses_ah", pc_ah - p0_ah, 16);

    // reset while the counter sits at two
    p0  = pc;
    seg = 7'h0F;
    tick(5);
    check_eq("midsettle_settling", {31'd0, stl}, 32'd1);
    rst = 1'b1;
    tick(1);
    check_eq("midsettle_rst", {26'd0, nib, vld, blk, err, pls, stl}, 32'd0);
    check_eq("midsettle_rst_ah",
             {26'd0, nib_ah, vld_ah, blk_ah, err_ah, pls_ah, stl_ah},
             32'd0);
    tick(2);
    check_eq("midsettle_no_pulse", pc - p0, 0);
    rst = 1'b0;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
